// File: rtl/muxn_pipe.sv
// Pipelined N:1 word multiplexer built from a binary tree of 2:1 stages, with a
// register stage every k tree levels and valid/ready flow control on both ends.
package constants;
  parameter int WORD_LENGTH = 32;
endpackage

module muxn_pipe #(
  parameter int n = constants::WORD_LENGTH,
  parameter int m = 32,
  parameter int k = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [m*n-1:0]       in,
  input  logic [$clog2(m)-1:0] sel,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [n-1:0]         out,
  output logic [$clog2(m)-1:0] out_sel,
  output logic                 out_valid,
  input  logic                 out_ready
);
  localparam int s  = $clog2(m);
  localparam int kk = (k < 1) ? 1 : k;
  localparam int L  = (s + kk - 1) / kk;

  if (m < 2 || (m & (m - 1)) != 0 || k < 1) begin : g_param_check
    $error("muxn_pipe: m must be a power of two >= 2 and k must be >= 1");
  end

  // Handshake: a word moves into the pipe on a rising edge when in_valid and
  // in_ready are both high; it leaves when out_valid and out_ready are both
  // high. All stages shift together, so in_ready is just the global advance.
  logic advance;
  assign advance  = out_ready | ~out_valid;
  assign in_ready = advance;

  for (genvar st = 0; st < L; st++) begin : g_stage
    localparam int LO = st * kk;
    localparam int HI = ((st + 1) * kk < s) ? (st + 1) * kk : s;
    localparam int WI = m >> LO;
    localparam int WO = m >> HI;

    logic [WI*n-1:0] src_w;
    logic [s-1:0]    src_tag;
    logic            src_v;
    logic [n-1:0]    node [WI];
    logic [WO*n-1:0] tree_w;
    logic [WO*n-1:0] w_d, w_q;
    logic [s-1:0]    tag_d, tag_q;
    logic            v_d, v_q;
    logic            load;

    if (st == 0) begin : g_src
      assign src_w   = in;
      assign src_tag = sel;
      assign src_v   = in_valid;
    end else begin : g_src
      assign src_w   = g_stage[st-1].w_q;
      assign src_tag = g_stage[st-1].tag_q;
      assign src_v   = g_stage[st-1].v_q;
    end

    // The full select rides along as the tag; the bits this stage consumes are
    // read straight from it, so no separate "remaining select" field is needed.
    always_comb begin
      for (int j = 0; j < WI; j++) node[j] = src_w[j*n +: n];
      for (int t = LO; t < HI; t++) begin
        for (int j = 0; j < (m >> (t + 1)); j++) begin
          node[j] = src_tag[t] ? node[2*j+1] : node[2*j];
        end
      end
      tree_w = '0;
      for (int j = 0; j < WO; j++) tree_w[j*n +: n] = node[j];
    end

    // Data and tag only load with a valid word, so the output holds its last
    // value while bubbles pass through.
    always_comb begin
      load  = advance & src_v;
      v_d   = advance ? src_v : v_q;
      w_d   = load ? tree_w : w_q;
      tag_d = load ? src_tag : tag_q;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v_q   <= 1'b0;
        w_q   <= '0;
        tag_q <= '0;
      end else begin
        v_q   <= v_d;
        w_q   <= w_d;
        tag_q <= tag_d;
      end
    end
  end

  assign out       = g_stage[L-1].w_q;
  assign out_sel   = g_stage[L-1].tag_q;
  assign out_valid = g_stage[L-1].v_q;
endmodule

// File: doc/muxn_pipe.md
# muxn_pipe

Parametrised, pipelined N-input word multiplexer with valid/ready flow control. It selects one of `m` channels, each `n` bits wide, through a binary tree of 2:1 stages. Pipeline registers are inserted every `k` tree levels. It replaces hand-built `_mux16`/`_mux32` trees on timing-critical paths such as register-file read, forwarding and writeback select in wide configurations. Each result carries the select value that produced it, so downstream logic can tag the data.

## Interface
- `n`, default `constants::WORD_LENGTH`: channel and output width in bits.
- `m`, default 32: channel count; power of two, ≥ 2.
- `k`, default 2: tree levels per pipeline stage; ≥ 1.
- Derived `s = $clog2(m)`: select width and number of tree levels.
- Derived `L = ceil(s / k)`: number of pipeline stages (latency).

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous reset, active-high.
- `in`  in  `m*n`  flattened channels; channel i at `in[i*n +: n]`.
- `sel`  in  `s`  channel select, sampled with `in`.
- `in_valid`  in  1  `in`/`sel` carry a request.
- `in_ready`  out  1  pipeline can accept this cycle.
- `out`  out  `n`  selected word.
- `out_sel`  out  `s`  `sel` value that produced `out`.
- `out_valid`  out  1  `out`/`out_sel` valid.
- `out_ready`  in  1  downstream accepts this cycle.

## Operation
- **Tree.** Level 0 pairs channels (2j, 2j+1) using `sel[0]`. Level t uses `sel[t]`. Level s−1 yields one word.
- **Registers.** Stage registers sit after levels k−1, 2k−1, … and always after level s−1, giving L stages.
- **Stage contents.** Each stage holds the surviving partial words, the unconsumed upper `sel` bits, the full `sel` for the tag, and a valid bit.
- **Advance condition.** `advance = out_ready | ~out_valid`. All stages load together on `advance`; otherwise all hold.
- **Input handshake.** `in_ready = advance`, purely combinational from `out_ready` and the last-stage valid. Acceptance happens when `in_valid & in_ready`.
- **Valid propagation.** Stage 0 valid loads `in_valid` on `advance`, so bubbles enter when `in_valid` is low. Bubbles are not collapsed; they shift through like data.
- **Sampling.** Channel data and `sel` are sampled only at acceptance. Later changes to `in` or `sel` do not affect a word already in flight.
- **Invalid stages.** Data of invalid stages is don't-care internally, but `out`/`out_sel` must hold their last values while `out_valid` = 0 after the first transfer.
- **Reset values.** On `rst` (async assert, release synchronous to `clk`), all stage valids, data and sel registers clear to 0: `out` = 0, `out_sel` = 0, `out_valid` = 0, `in_ready` = 1.
- **Reset mid-operation.** All in-flight words are discarded; nothing is emitted after release until new acceptances.
- **Elaboration checks.** m not a power of two, m < 2, or k < 1 is an elaboration error (`$error`).

## Timing
- **Latency.** A word accepted at edge T is presented with `out_valid` = 1 after edge T+L−1, i.e. visible in the cycle following edge T+L−1, when there are no stalls. Default m=32, k=2 gives s=5 and L=3.
- **Degenerate case.** k ≥ s gives L=1: single register stage, registered output only.
- **Throughput.** One word per cycle with `out_ready` held high.
- **Stall.** `out_valid` & ~`out_ready` freezes every stage and drops `in_ready` in the same cycle. No word is lost or duplicated.
- **Simultaneous events.** With `out_valid` & `out_ready` & `in_valid`, the output transfers and a new word is accepted on the same edge.
- **Stalled input.** A word offered while `in_ready` = 0 is not taken; the source must hold it.
- **Combinational paths.** No combinational path from `in`/`sel` to `out`. The only combinational path is `out_ready` → `in_ready`.

## Test plan
- **Reset.** Assert `rst` mid-cycle with 3 words in flight → outputs clear immediately (0/0/0, `in_ready`=1). After release with `in_valid`=0 for 10 cycles, `out_valid` stays 0.
- **Sweep.** Defaults; channel i = 32'hA500_0000+i; back-to-back `sel` = 0..31 with `out_ready`=1 → first `out`=32'hA500_0000 with `out_sel`=0 three cycles after the first acceptance, then one word per cycle in order through 32'hA500_001F with `out_sel`=31.
- **Sampling.** Accept `sel`=7, then change channel 7 to 32'hDEAD_BEEF on the next cycle → output carries the old channel 7 value.
- **Backpressure.** Stream 8 words, drop `out_ready` for 4 cycles on word 3 → `in_ready`=0 during the stall. The received sequence equals the sent sequence, with no duplicates or drops; word 3 is held stable throughout.
- **Bubbles.** `in_valid` pattern 1,0,1,1,0 → `out_valid` reproduces the same pattern delayed by L cycles.
- **Parameter sweep.** (n=8, m=2, k=1, L=1), (n=16, m=8, k=2, L=2), (n=32, m=64, k=4, L=2) against a scoreboard model → all match under random valid/ready.
